// File: rtl/genblk_array_reader_pkg.sv
// Shared types for the generate-array hierarchy reader: the sweep FSM state
// encoding and its raw 2-bit container type.
package genblk_reader_pkg;

    typedef logic [1:0] state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/genblk_array_reader_if.sv
// Bundles the cell write port, the sweep request/status and the record
// valid/ready stream of genblk_array_reader into one interface.
interface genblk_array_reader_if #(
    parameter int unsigned NUM_INST = 4,
    parameter int unsigned DATA_W   = 1
);
    localparam int unsigned IDX_W = (NUM_INST > 1) ? $clog2(NUM_INST) : 1;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic              scan_start;
    logic              busy;
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  out_idx;
    logic [DATA_W-1:0] out_data;
    logic              scan_done;

    // Producer of writes and sweep requests, consumer of records
    modport master (
        output wr_en, wr_idx, wr_data, scan_start, out_ready,
        input  busy, out_valid, out_idx, out_data, scan_done
    );

    // The reader itself
    modport slave (
        input  wr_en, wr_idx, wr_data, scan_start, out_ready,
        output busy, out_valid, out_idx, out_data, scan_done
    );

endinterface

// File: rtl/genblk_array_reader_leaf_cell.sv
// One storage leaf of the generated array. It deliberately has no output
// port: its contents are only observed through hierarchical references.
module genblk_leaf_cell #(
    parameter int unsigned DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [DATA_W-1:0] wd_i
);

    logic [DATA_W-1:0] val;

    // Storage register, cleared by reset, loaded on write strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            val <= '0;
        end else if (we_i) begin
            val <= wd_i;
        end
    end

endmodule

// File: rtl/genblk_array_reader.sv
// Generate-array hierarchy reader: owns NUM_INST leaf cells, reads them back
// through cell_b[i].cell_inst.val references and streams (index, value)
// records over a valid/ready handshake on each requested sweep.
// Optional build macro GENBLK_READER_CHANGE_ONLY_EN: emit only cells whose
// value differs from the value last emitted for that cell.
module genblk_array_reader
    import genblk_reader_pkg::*;
#(
    parameter int unsigned NUM_INST = 4,
    parameter int unsigned DATA_W   = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    genblk_array_reader_if.slave bus
);

    localparam int unsigned IDX_W = (NUM_INST > 1) ? $clog2(NUM_INST) : 1;

    logic [NUM_INST-1:0] cell_we_c;
    logic [DATA_W-1:0]   cell_val_c [NUM_INST];

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic              busy_q, busy_d;
    logic              out_valid_q, out_valid_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              scan_done_q, scan_done_d;

    logic [IDX_W-1:0]  cand_idx_c;
    logic [DATA_W-1:0] cand_data_c;
    logic              cand_emit_c;
    logic              advance_c;

    // Leaf array; an out-of-range wr_idx matches no cell and is dropped
    for (genvar i = 0; i < NUM_INST; i++) begin : cell_b
        assign cell_we_c[i] = bus.wr_en && (bus.wr_idx == IDX_W'(i));

        genblk_leaf_cell #(
            .DATA_W (DATA_W)
        ) cell_inst (
            .clk   (clk),
            .rst_n (rst_n),
            .we_i  (cell_we_c[i]),
            .wd_i  (bus.wr_data)
        );
    end

    // Readback purely through hierarchical references into the leaves
    for (genvar i = 0; i < NUM_INST; i++) begin : rd_b
        assign cell_val_c[i] = cell_b[i].cell_inst.val;
    end

    // Next cell to present: index 0 when starting, ptr+1 while sweeping
    always_comb begin
        cand_idx_c  = (state_q == SCAN) ? (ptr_q + IDX_W'(1)) : '0;
        cand_data_c = '0;
        for (int i = 0; i < NUM_INST; i++) begin
            if (cand_idx_c == IDX_W'(i)) begin
                cand_data_c = cell_val_c[i];
            end
        end
    end

`ifdef GENBLK_READER_CHANGE_ONLY_EN
    logic [DATA_W-1:0] shadow_q [NUM_INST];
    logic [DATA_W-1:0] shadow_d [NUM_INST];
    logic [DATA_W-1:0] cand_shadow_c;

    // Candidate is emitted only if it differs from its last emitted value
    always_comb begin
        cand_shadow_c = '0;
        for (int i = 0; i < NUM_INST; i++) begin
            if (cand_idx_c == IDX_W'(i)) begin
                cand_shadow_c = shadow_q[i];
            end
        end
        cand_emit_c = (cand_data_c != cand_shadow_c);
    end

    // Shadow copies of the last emitted value per cell
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_INST; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            shadow_q <= shadow_d;
        end
    end
`else
    assign cand_emit_c = 1'b1;
`endif

    // Sweep FSM next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;
        scan_done_d = 1'b0;
        advance_c   = 1'b0;
`ifdef GENBLK_READER_CHANGE_ONLY_EN
        shadow_d    = shadow_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.scan_start) begin
                    state_d     = SCAN;
                    busy_d      = 1'b1;
                    ptr_d       = '0;
                    out_valid_d = cand_emit_c;
                    if (cand_emit_c) begin
                        out_idx_d  = cand_idx_c;
                        out_data_d = cand_data_c;
                    end
                end
            end

            SCAN: begin
                // Move on after a handshake, or every cycle while skipping
                advance_c = !out_valid_q || bus.out_ready;
                if (advance_c) begin
`ifdef GENBLK_READER_CHANGE_ONLY_EN
                    if (out_valid_q) begin
                        for (int i = 0; i < NUM_INST; i++) begin
                            if (ptr_q == IDX_W'(i)) begin
                                shadow_d[i] = out_data_q;
                            end
                        end
                    end
`endif
                    if (ptr_q == IDX_W'(NUM_INST - 1)) begin
                        state_d     = DONE;
                        out_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        scan_done_d = 1'b1;
                    end else begin
                        ptr_d       = cand_idx_c;
                        out_valid_d = cand_emit_c;
                        if (cand_emit_c) begin
                            out_idx_d  = cand_idx_c;
                            out_data_d = cand_data_c;
                        end
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
            scan_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
            scan_done_q <= scan_done_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_data  = out_data_q;
    assign bus.scan_done = scan_done_q;

endmodule
